// File: rtl/adc_sdram_burst_master.sv
// ----------------------------------------------------------------------------
// adc_sdram_burst_master
//
// ADC capture sequencer. A falling edge on the active-low start request begins
// a capture of N = SAMPLES*NUM_CH words. The ADC samples arrive round-robin
// across channels, channel 0 first. Each sample is written to SDRAM through a
// valid/ready command port, at consecutive word addresses starting at
// BASE_ADDR. In readback mode the block is then read back in address order.
// Each returned word is streamed out as a one-cycle out_valid pulse.
//
// Ports
//   clk           rising-edge clock for all logic
//   reset         asynchronous, active-high reset
//   start         active-low request; a 1->0 edge seen in IDLE starts a capture
//   readback      latched with the request: 1 = write then read back
//   adc_valid     adc_data carries a new sample (the ADC cannot be stalled)
//   adc_data      ADC sample
//   cmd_valid     SDRAM command present
//   cmd_ready     controller accepts the command when cmd_valid && cmd_ready
//   cmd_rw        0 = write, 1 = read
//   cmd_addr      SDRAM word address
//   cmd_wdata     write data
//   cmd_byte_sel  byte enables, always all ones
//   rd_valid      read data return, in command order
//   rd_data       read data
//   out_valid     readback word valid, one cycle after the matching rd_valid
//   out_data      readback word
//   busy          high whenever the sequencer is not idle
//   done          one-cycle pulse on the way back to IDLE
//   overrun       sticky: a sample was dropped during the write phase
// ----------------------------------------------------------------------------
module adc_sdram_burst_master #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 32,
  parameter int                NUM_CH    = 2,
  parameter int                SAMPLES   = 128,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  readback,
  input  logic                  adc_valid,
  input  logic [DATA_W-1:0]     adc_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_rw,
  output logic [ADDR_W-1:0]     cmd_addr,
  output logic [DATA_W-1:0]     cmd_wdata,
  output logic [DATA_W/8-1:0]   cmd_byte_sel,
  input  logic                  rd_valid,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int N  = SAMPLES * NUM_CH;
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              start_prev;
  logic              request;
  logic              rb_mode;

  // Single-entry hold register between the free-running ADC and the
  // stallable command port.
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;

  // wr_cnt counts accepted writes (drives the address); cap_cnt counts
  // captured samples, which runs one ahead of wr_cnt while the hold is full.
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     cap_cnt;
  logic [CW-1:0]     rd_iss;
  logic [CW-1:0]     rd_ret;

  logic              wr_acc;
  logic              cap_ok;
  logic              capture;
  logic              drop;
  logic              rd_acc;
  logic              rd_take;

  assign request = start_prev & ~start;

  assign wr_acc  = (state == S_WRITE) & hold_full & cmd_ready;
  assign cap_ok  = (state == S_WRITE) & adc_valid & (cap_cnt < N_C);
  // A sample fits if the hold is empty or is being drained this very cycle,
  // which gives one sample per cycle with no bubble while cmd_ready is high.
  assign capture = cap_ok & (~hold_full | cmd_ready);
  assign drop    = cap_ok & hold_full & ~cmd_ready;

  assign rd_acc  = (state == S_READ) & (rd_iss < N_C) & cmd_ready;
  assign rd_take = (state == S_READ) & rd_valid & (rd_ret < N_C);

  assign cmd_byte_sel = '1;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and command-port outputs
  always_comb begin
    state_nxt = state;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (request) begin
          state_nxt = S_WRITE;
        end
      end

      S_WRITE: begin
        cmd_valid = hold_full;
        cmd_addr  = BASE_ADDR + ADDR_W'(wr_cnt);
        cmd_wdata = hold_data;
        if (wr_acc && (wr_cnt == LAST_C)) begin
          state_nxt = rb_mode ? S_READ : S_DONE;
        end
      end

      S_READ: begin
        cmd_valid = (rd_iss < N_C);
        cmd_rw    = 1'b1;
        cmd_addr  = BASE_ADDR + ADDR_W'(rd_iss);
        if (rd_take && (rd_ret == LAST_C)) begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: start edge, hold register, counters, readback output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b1;
      rb_mode    <= 1'b0;
      hold_full  <= 1'b0;
      hold_data  <= '0;
      wr_cnt     <= '0;
      cap_cnt    <= '0;
      rd_iss     <= '0;
      rd_ret     <= '0;
      overrun    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      start_prev <= start;
      out_valid  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (request) begin
            rb_mode   <= readback;
            overrun   <= 1'b0;
            hold_full <= 1'b0;
            wr_cnt    <= '0;
            cap_cnt   <= '0;
            rd_iss    <= '0;
            rd_ret    <= '0;
          end
        end

        S_WRITE: begin
          if (wr_acc) begin
            wr_cnt <= wr_cnt + 1'b1;
          end
          if (capture) begin
            hold_data <= adc_data;
            hold_full <= 1'b1;
            cap_cnt   <= cap_cnt + 1'b1;
          end else if (wr_acc) begin
            hold_full <= 1'b0;
          end
          // Dropped samples do not consume an address: the stream simply
          // has a gap, flagged by the sticky overrun.
          if (drop) begin
            overrun <= 1'b1;
          end
        end

        S_READ: begin
          if (rd_acc) begin
            rd_iss <= rd_iss + 1'b1;
          end
          if (rd_take) begin
            out_data  <= rd_data;
            out_valid <= 1'b1;
            rd_ret    <= rd_ret + 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sdram_burst_master.sv
// ----------------------------------------------------------------------------
// tb_adc_sdram_burst_master
//
// Directed bench for adc_sdram_burst_master with NUM_CH=2, SAMPLES=4 (N=8),
// BASE_ADDR=0. A background monitor logs accepted commands, readback words
// and done pulses; a simple controller model answers each read with
// rd_data = addr + 0x100 three cycles after acceptance.
// ----------------------------------------------------------------------------
module tb_adc_sdram_burst_master;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 32;
  localparam int NUM_CH  = 2;
  localparam int SAMPLES = 4;
  localparam int N       = 8;

  logic                clk;
  logic                reset;
  logic                start;
  logic                readback;
  logic                adc_valid;
  logic [DATA_W-1:0]   adc_data;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_rw;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_byte_sel;
  logic                rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                busy;
  logic                done;
  logic                overrun;

  int n_cmp = 0;
  int n_err = 0;

  adc_sdram_burst_master #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_CH   (NUM_CH),
    .SAMPLES  (SAMPLES),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .readback    (readback),
    .adc_valid   (adc_valid),
    .adc_data    (adc_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_byte_sel(cmd_byte_sel),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [DATA_W-1:0] wq_data[$];
  logic [DATA_W-1:0] oq[$];
  logic [ADDR_W-1:0] pend_addr[$];
  int                pend_due[$];
  int                rd_acc_cnt = 0;
  int                done_cnt   = 0;
  int                lat_err    = 0;
  logic              rdv_prev   = 1'b0;

  // Monitor: samples at the falling edge what the DUT acts on next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_valid && cmd_ready && !cmd_rw) begin
        wq_addr.push_back(cmd_addr);
        wq_data.push_back(cmd_wdata);
      end
      if (cmd_valid && cmd_ready && cmd_rw) begin
        rd_acc_cnt++;
        pend_addr.push_back(cmd_addr);
        pend_due.push_back(cyc + 3);
      end
      if (out_valid) oq.push_back(out_data);
      if (out_valid !== rdv_prev) lat_err++;
      rdv_prev = rd_valid;
      if (done) done_cnt++;
    end
  end

  // Controller read-return model
  initial begin
    rd_valid = 1'b0;
    rd_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      rd_valid = 1'b0;
      rd_data  = '0;
      if (pend_due.size() > 0 && cyc >= pend_due[0]) begin
        rd_valid = 1'b1;
        rd_data  = pend_addr.pop_front() + 32'h100;
        void'(pend_due.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wq_addr.delete();
    wq_data.delete();
    oq.delete();
    rd_acc_cnt = 0;
    done_cnt   = 0;
    lat_err    = 0;
  endtask

  // Leaves start low; the request is registered at the posedge inside step().
  task automatic do_start(input logic rb);
    start    = 1'b0;
    readback = rb;
    step();
  endtask

  task automatic send(input logic [DATA_W-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      adc_valid = 1'b1;
      adc_data  = first + DATA_W'(i);
      step();
    end
    adc_valid = 1'b0;
    adc_data  = '0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0 && !busy) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
    repeat (5) step();
  endtask

  task automatic test_reset();
    bit to;
    int lim;
    // state while reset is held from power-up
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL por_busy got %b want 0", busy); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL por_cmd_valid got %b want 0", cmd_valid); end
    n_cmp++; if (cmd_byte_sel !== 2'b11) begin n_err++; $display("FAIL por_byte_sel got %b want 11", cmd_byte_sel); end
    n_cmp++; if (done !== 1'b0 || overrun !== 1'b0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL por_flags got done=%b ovr=%b ov=%b want 000", done, overrun, out_valid); end
    step();
    reset = 1'b0;
    step();

    clear_logs();
    do_start(1'b0);
    start = 1'b1;
    send(16'h050, 5);
    step();
    n_cmp++; if (wq_addr.size() !== 5) begin n_err++; $display("FAIL mid_writes got %0d want 5", wq_addr.size()); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", busy); end

    reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (cmd_valid !== 1'b0 || cmd_addr !== 32'h0 || cmd_wdata !== 16'h0) begin
      n_err++; $display("FAIL rst_cmd got v=%b a=%h d=%h want 0/0/0", cmd_valid, cmd_addr, cmd_wdata); end
    n_cmp++; if (done !== 1'b0 || overrun !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0) begin
      n_err++; $display("FAIL rst_outs got done=%b ovr=%b ov=%b od=%h want zeros", done, overrun, out_valid, out_data); end
    n_cmp++; if (cmd_byte_sel !== 2'b11) begin n_err++; $display("FAIL rst_byte_sel got %b want 11", cmd_byte_sel); end
    step();
    reset = 1'b0;
    step();

    clear_logs();
    do_start(1'b0);
    start = 1'b1;
    send(16'h060, 8);
    wait_idle(60, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL rst_restart_timeout got busy want idle"); end
    n_cmp++; if (wq_addr.size() !== N) begin n_err++; $display("FAIL rst_restart_count got %0d want 8", wq_addr.size()); end
    lim = (wq_addr.size() < N) ? wq_addr.size() : N;
    for (int i = 0; i < lim; i++) begin
      n_cmp++; if (wq_addr[i] !== 32'(i) || wq_data[i] !== 16'h060 + 16'(i)) begin
        n_err++; $display("FAIL rst_restart_wr%0d got a=%h d=%h want a=%h d=%h", i, wq_addr[i], wq_data[i], i, 16'h060 + 16'(i)); end
    end
  endtask

  task automatic test_write_only();
    bit to;
    int lim;
    clear_logs();
    do_start(1'b0);
    start = 1'b1;
    send(16'h100, 8);
    wait_idle(60, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL wo_timeout got busy want idle"); end
    n_cmp++; if (wq_addr.size() !== N) begin n_err++; $display("FAIL wo_count got %0d want 8", wq_addr.size()); end
    lim = (wq_addr.size() < N) ? wq_addr.size() : N;
    for (int i = 0; i < lim; i++) begin
      n_cmp++; if (wq_addr[i] !== 32'(i) || wq_data[i] !== 16'h100 + 16'(i)) begin
        n_err++; $display("FAIL wo_wr%0d got a=%h d=%h want a=%h d=%h", i, wq_addr[i], wq_data[i], i, 16'h100 + 16'(i)); end
    end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL wo_overrun got %b want 0", overrun); end
    n_cmp++; if (rd_acc_cnt !== 0 || oq.size() !== 0) begin
      n_err++; $display("FAIL wo_no_reads got reads=%0d outs=%0d want 0/0", rd_acc_cnt, oq.size()); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL wo_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_readback();
    bit to;
    int lim;
    clear_logs();
    do_start(1'b1);
    start    = 1'b1;
    readback = 1'b0;
    send(16'h100, 8);
    wait_idle(120, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL rb_timeout got busy want idle"); end
    n_cmp++; if (wq_addr.size() !== N) begin n_err++; $display("FAIL rb_writes got %0d want 8", wq_addr.size()); end
    n_cmp++; if (rd_acc_cnt !== N) begin n_err++; $display("FAIL rb_reads got %0d want 8", rd_acc_cnt); end
    n_cmp++; if (oq.size() !== N) begin n_err++; $display("FAIL rb_outs got %0d want 8", oq.size()); end
    lim = (oq.size() < N) ? oq.size() : N;
    for (int i = 0; i < lim; i++) begin
      n_cmp++; if (oq[i] !== 16'h100 + 16'(i)) begin
        n_err++; $display("FAIL rb_out%0d got %h want %h", i, oq[i], 16'h100 + 16'(i)); end
    end
    n_cmp++; if (lat_err !== 0) begin n_err++; $display("FAIL rb_latency got %0d misaligned cycles want 0", lat_err); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL rb_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_overrun();
    bit to;
    int lim;
    logic [DATA_W-1:0] exp_d[8] = '{16'h200, 16'h201, 16'h206, 16'h207,
                                    16'h208, 16'h209, 16'h20A, 16'h20B};
    clear_logs();
    do_start(1'b0);
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      adc_valid = 1'b1;
      adc_data  = 16'h200 + 16'(i);
      cmd_ready = !(i >= 2 && i <= 5);
      step();
    end
    adc_valid = 1'b0;
    cmd_ready = 1'b1;
    wait_idle(60, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL ovr_timeout got busy want idle"); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got %b want 1", overrun); end
    n_cmp++; if (wq_addr.size() !== N) begin n_err++; $display("FAIL ovr_count got %0d want 8", wq_addr.size()); end
    lim = (wq_addr.size() < N) ? wq_addr.size() : N;
    for (int i = 0; i < lim; i++) begin
      n_cmp++; if (wq_addr[i] !== 32'(i) || wq_data[i] !== exp_d[i]) begin
        n_err++; $display("FAIL ovr_wr%0d got a=%h d=%h want a=%h d=%h", i, wq_addr[i], wq_data[i], i, exp_d[i]); end
    end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL ovr_done got %0d want 1", done_cnt); end

    clear_logs();
    do_start(1'b0);
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear got %b want 0", overrun); end
    start = 1'b1;
    send(16'h280, 8);
    wait_idle(60, to);
    n_cmp++; if (to || overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clean_run got to=%b ovr=%b want 0/0", to, overrun); end
  endtask

  task automatic test_second_start();
    bit to;
    int lim;
    clear_logs();
    do_start(1'b0);
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) start = 1'b1;
      if (i == 3) start = 1'b0;
      adc_valid = 1'b1;
      adc_data  = 16'h300 + 16'(i);
      step();
    end
    adc_valid = 1'b0;
    wait_idle(60, to);
    repeat (20) step();
    n_cmp++; if (to) begin n_err++; $display("FAIL s2_timeout got busy want idle"); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL s2_done got %0d want 1", done_cnt); end
    n_cmp++; if (wq_addr.size() !== N || busy !== 1'b0) begin
      n_err++; $display("FAIL s2_writes got %0d busy=%b want 8 busy=0", wq_addr.size(), busy); end
    lim = (wq_data.size() < N) ? wq_data.size() : N;
    for (int i = 0; i < lim; i++) begin
      n_cmp++; if (wq_data[i] !== 16'h300 + 16'(i)) begin
        n_err++; $display("FAIL s2_wr%0d got %h want %h", i, wq_data[i], 16'h300 + 16'(i)); end
    end
    start = 1'b1;
    step();
  endtask

  task automatic test_held_low();
    bit to;
    clear_logs();
    do_start(1'b0);
    send(16'h400, 8);
    repeat (12) step();
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL hl_done got %0d want 1", done_cnt); end
    n_cmp++; if (wq_addr.size() !== N || busy !== 1'b0) begin
      n_err++; $display("FAIL hl_single got writes=%0d busy=%b want 8 busy=0", wq_addr.size(), busy); end
    start = 1'b1;
    step();

    clear_logs();
    do_start(1'b0);
    start = 1'b1;
    send(16'h500, 8);
    wait_idle(60, to);
    n_cmp++; if (to || done_cnt !== 1) begin n_err++; $display("FAIL hl_second_done got to=%b done=%0d want 0/1", to, done_cnt); end
    n_cmp++; if (wq_addr.size() !== N) begin n_err++; $display("FAIL hl_second_count got %0d want 8", wq_addr.size()); end
    if (wq_addr.size() > 0) begin
      n_cmp++; if (wq_addr[0] !== 32'h0 || wq_data[0] !== 16'h500) begin
        n_err++; $display("FAIL hl_second_base got a=%h d=%h want a=0 d=0500", wq_addr[0], wq_data[0]); end
      n_cmp++; if (wq_addr[wq_addr.size()-1] !== 32'h7) begin
        n_err++; $display("FAIL hl_second_last got a=%h want 7", wq_addr[wq_addr.size()-1]); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b1;
    readback  = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    cmd_ready = 1'b1;
    step();

    test_reset();
    test_write_only();
    test_readback();
    test_overrun();
    test_second_start();
    test_held_low();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
